// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes,
// halt causes and the wait-state helper.
package cpu_seq_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_F_REQ  = 4'd1;
  localparam logic [3:0] ST_F_WAIT = 4'd2;
  localparam logic [3:0] ST_DECODE = 4'd3;
  localparam logic [3:0] ST_EXEC   = 4'd4;
  localparam logic [3:0] ST_M_REQ  = 4'd5;
  localparam logic [3:0] ST_M_WAIT = 4'd6;
  localparam logic [3:0] ST_WB     = 4'd7;
  localparam logic [3:0] ST_HALT   = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE   = ST_IDLE,
    S_F_REQ  = ST_F_REQ,
    S_F_WAIT = ST_F_WAIT,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_M_REQ  = ST_M_REQ,
    S_M_WAIT = ST_M_WAIT,
    S_WB     = ST_WB,
    S_HALT   = ST_HALT
  } state_e;

  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_EBREAK  = 2'b01;
  localparam logic [1:0] HALT_ILLEGAL = 2'b10;
  localparam logic [1:0] HALT_TIMEOUT = 2'b11;

  function automatic logic is_mem_wait(input state_e s);
    return (s == S_F_REQ) || (s == S_F_WAIT) ||
           (s == S_M_REQ) || (s == S_M_WAIT);
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_tmo.sv
// Saturating stall counter; flags expiry on the stalled cycle
// that reaches the limit. A zero limit never expires.
module seq_timeout_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && r_cnt != '1) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = i_en && (i_limit != '0) &&
                     (r_cnt >= i_limit - W'(1));

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle RV32 sequencer. Define CPU_SEQ_PERF_EN to build the
// cycle/instret counters; otherwise those ports read zero.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rsp_data,
  output logic [XLEN-1:0]  ir,
  input  logic             op_load,
  input  logic             op_store,
  input  logic             op_ebreak,
  input  logic             op_illegal,
  output logic             dmem_req_valid,
  output logic             dmem_req_we,
  input  logic             dmem_req_ready,
  input  logic             dmem_rsp_valid,
  output logic             pc_we,
  output logic             reg_we,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e          r_state;
  state_e          w_next;
  logic [XLEN-1:0] r_ir;
  logic            r_store;
  logic [1:0]      r_cause;
  logic [1:0]      w_cause;
  logic            w_stall;
  logic            w_expired;

  seq_timeout_cnt #(.W(32)) u_tmo (
    .clk       (clk),
    .rst_n     (rst),
    .i_clr     (w_next != r_state),
    .i_en      (w_stall),
    .i_limit   (32'(TIMEOUT)),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_cause = HALT_NONE;
    unique case (r_state)
      S_IDLE:   if (run) w_next = S_F_REQ;
      S_F_REQ:
        if (imem_req_ready) w_next = S_F_WAIT;
        else w_stall = 1'b1;
      S_F_WAIT:
        if (imem_rsp_valid) w_next = S_DECODE;
        else w_stall = 1'b1;
      S_DECODE:
        if (op_illegal) begin
          w_next  = S_HALT;
          w_cause = HALT_ILLEGAL;
        end else if (op_ebreak) begin
          w_next  = S_HALT;
          w_cause = HALT_EBREAK;
        end else begin
          w_next = S_EXEC;
        end
      S_EXEC:
        w_next = (op_load || op_store) ? S_M_REQ : S_WB;
      S_M_REQ:
        if (dmem_req_ready) w_next = S_M_WAIT;
        else w_stall = 1'b1;
      S_M_WAIT:
        if (dmem_rsp_valid) w_next = S_WB;
        else w_stall = 1'b1;
      S_WB:     w_next = run ? S_F_REQ : S_IDLE;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
    // A stall that hits the limit overrides staying put.
    if (w_stall && w_expired && is_mem_wait(r_state)) begin
      w_next  = S_HALT;
      w_cause = HALT_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_store <= 1'b0;
      r_cause <= HALT_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == S_F_WAIT && imem_rsp_valid) r_ir <= imem_rsp_data;
      if (r_state == S_EXEC) r_store <= op_store;
      if (w_next == S_HALT && r_state != S_HALT) r_cause <= w_cause;
    end
  end

  assign ir             = r_ir;
  assign imem_req_valid = (r_state == S_F_REQ);
  assign dmem_req_valid = (r_state == S_M_REQ);
  assign dmem_req_we    = (r_state == S_M_REQ) && r_store;
  assign pc_we          = (r_state == S_WB);
  assign reg_we         = (r_state == S_WB) && !r_store;
  assign halted         = (r_state == S_HALT);
  assign halt_cause     = r_cause;

`ifdef CPU_SEQ_PERF_EN
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_ret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALT) r_cyc <= r_cyc + CNT_W'(1);
      if (r_state == S_WB) r_ret <= r_ret + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cyc;
  assign instret_cnt = r_ret;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: per-cycle expected outputs are expanded
// from the instruction kind and randomized handshake delays.
module tb_cpu_seq_ctrl;

  localparam int XLEN  = 32;
  localparam int TMO   = 4;
  localparam int CNT_W = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run = 1'b0;
  logic             imem_req_valid;
  logic             imem_req_ready = 1'b0;
  logic             imem_rsp_valid = 1'b0;
  logic [XLEN-1:0]  imem_rsp_data = '0;
  logic [XLEN-1:0]  ir;
  logic             op_load, op_store, op_ebreak, op_illegal;
  logic             dmem_req_valid, dmem_req_we;
  logic             dmem_req_ready = 1'b0;
  logic             dmem_rsp_valid = 1'b0;
  logic             pc_we, reg_we, halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  longint m_cyc = 0;
  longint m_ret = 0;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.XLEN(XLEN), .TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ir             (ir),
    .op_load        (op_load),
    .op_store       (op_store),
    .op_ebreak      (op_ebreak),
    .op_illegal     (op_illegal),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_ready (dmem_req_ready),
    .dmem_rsp_valid (dmem_rsp_valid),
    .pc_we          (pc_we),
    .reg_we         (reg_we),
    .halted         (halted),
    .halt_cause     (halt_cause),
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt)
  );

  function automatic logic is_illegal(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17,
      7'h6f, 7'h67, 7'h63, 7'h73, 7'h0f: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Stand-in for the ControlUnit, decoding the live instruction register.
  assign op_load    = (ir[6:0] == 7'h03);
  assign op_store   = (ir[6:0] == 7'h23);
  assign op_ebreak  = (ir == 32'h0010_0073);
  assign op_illegal = is_illegal(ir);

  typedef struct packed {
    logic       ireq, irdy, irsp, junk_i;
    logic       dreq, drdy, drsp, junk_d;
    logic       we, pcw, rgw, hlt;
    logic [1:0] cause;
    logic       chk_ir, wb;
  } cyc_t;

  cyc_t sched[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rp < 0 means the fetch response never arrives.
  task automatic plan(input logic [31:0] ins, input int rq, input int rp,
                      input int dq, input int dp);
    cyc_t c;
    logic ld, st, eb, il;
    ld = (ins[6:0] == 7'h03);
    st = (ins[6:0] == 7'h23);
    eb = (ins == 32'h0010_0073);
    il = is_illegal(ins);
    sched.delete();
    for (int i = 0; i <= rq; i++) begin
      c = '0; c.ireq = 1'b1; c.irdy = (i == rq); c.junk_i = (i != rq);
      sched.push_back(c);
    end
    if (rp < 0) begin
      for (int i = 0; i < TMO; i++) begin
        c = '0; sched.push_back(c);
      end
      for (int i = 0; i < 3; i++) begin
        c = '0; c.hlt = 1'b1; c.cause = 2'b11; sched.push_back(c);
      end
      return;
    end
    for (int i = 0; i <= rp; i++) begin
      c = '0; c.irsp = (i == rp); sched.push_back(c);
    end
    c = '0; c.chk_ir = 1'b1; c.junk_i = 1'b1; c.junk_d = 1'b1;
    sched.push_back(c);
    if (il || eb) begin
      for (int i = 0; i < 3; i++) begin
        c = '0; c.hlt = 1'b1; c.chk_ir = 1'b1;
        c.cause = il ? 2'b10 : 2'b01;
        sched.push_back(c);
      end
      return;
    end
    c = '0; c.junk_d = 1'b1; sched.push_back(c);
    if (ld || st) begin
      for (int i = 0; i <= dq; i++) begin
        c = '0; c.dreq = 1'b1; c.we = st; c.drdy = (i == dq);
        c.junk_d = (i != dq);
        sched.push_back(c);
      end
      for (int i = 0; i <= dp; i++) begin
        c = '0; c.drsp = (i == dp); sched.push_back(c);
      end
    end
    c = '0; c.pcw = 1'b1; c.rgw = !st; c.wb = 1'b1; c.chk_ir = 1'b1;
    sched.push_back(c);
  endtask

  task automatic clr_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
  endtask

  // Called at a falling edge with the DUT in the first planned cycle.
  task automatic exec(input logic [31:0] ins, input logic run_after,
                      input int ncyc);
    cyc_t c;
    for (int k = 0; k < sched.size() && k < ncyc; k++) begin
      c = sched[k];
      imem_req_ready = c.irdy;
      imem_rsp_valid = c.irsp | (c.junk_i & 1'($urandom_range(0, 1)));
      imem_rsp_data  = c.irsp ? ins : $urandom();
      dmem_req_ready = c.drdy;
      dmem_rsp_valid = c.drsp | (c.junk_d & 1'($urandom_range(0, 1)));
      if (c.wb) run = run_after;
      chk("imem_req_valid", imem_req_valid, c.ireq);
      chk("dmem_req_valid", dmem_req_valid, c.dreq);
      if (c.dreq) chk("dmem_req_we", dmem_req_we, c.we);
      chk("pc_we", pc_we, c.pcw);
      chk("reg_we", reg_we, c.rgw);
      chk("halted", halted, c.hlt);
      if (c.hlt) chk("halt_cause", halt_cause, c.cause);
      if (c.chk_ir) chk("ir", ir, ins);
      if (c.wb) begin
`ifdef CPU_SEQ_PERF_EN
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("instret_cnt", instret_cnt, m_ret);
`else
        chk("cycle_cnt", cycle_cnt, 0);
        chk("instret_cnt", instret_cnt, 0);
`endif
      end
      @(posedge clk);
      if (!c.hlt) m_cyc++;
      if (c.wb) m_ret++;
      @(negedge clk);
    end
    clr_inputs();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"},
        {imem_req_valid, dmem_req_valid, dmem_req_we,
         pc_we, reg_we, halted, halt_cause}, 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_cyc"}, cycle_cnt, 0);
    chk({tag, "_ret"}, instret_cnt, 0);
  endtask

  // Leaves the DUT in its first F_REQ cycle at a falling edge.
  task automatic do_reset(input string tag);
    clr_inputs();
    run = 1'b0;
    #2 rst = 1'b0;
    #1 chk_zero(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    m_cyc = 0;
    m_ret = 0;
    chk_zero({tag, "_idle"});
    @(negedge clk);
  endtask

  logic [31:0] tbl [5] = '{32'h0050_0093, 32'h0020_81b3, 32'h0001_2083,
                           32'h0011_2023, 32'h1234_52b7};

  initial begin
    logic [31:0] ins;
    do_reset("reset");

    plan(32'h0050_0093, 0, 0, 0, 0);
    exec(32'h0050_0093, 1'b1, 1000);

    plan(32'h0010_0113, 3, 0, 0, 0);
    exec(32'h0010_0113, 1'b1, 1000);

    plan(32'h0011_2023, 0, 0, 0, 2);
    exec(32'h0011_2023, 1'b1, 1000);

    plan(32'h0001_2083, 1, 1, 1, 1);
    exec(32'h0001_2083, 1'b1, 1000);

    for (int n = 0; n < 24; n++) begin
      ins = tbl[$urandom_range(0, 4)];
      plan(ins, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3));
      exec(ins, (n != 23), 1000);
    end

    for (int i = 0; i < 3; i++) begin
      chk("idle_no_req", {imem_req_valid, pc_we, halted}, 0);
      @(negedge clk);
    end
    run = 1'b1;
    @(negedge clk);
    plan(32'h0000_0013, 0, 0, 0, 0);
    exec(32'h0000_0013, 1'b1, 1000);

    plan(32'h0001_2083, 0, 0, 0, 3);
    exec(32'h0001_2083, 1'b1, 5);
    chk("in_mwait_no_req", {imem_req_valid, dmem_req_valid, pc_we}, 0);
    do_reset("mwait_rst");

    plan(32'h0010_0073, 0, 1, 0, 0);
    exec(32'h0010_0073, 1'b1, 1000);
    do_reset("ebreak_rst");

    plan(32'hFFFF_FFFF, 2, 0, 0, 0);
    exec(32'hFFFF_FFFF, 1'b1, 1000);
    do_reset("illegal_rst");

    plan(32'h0, 0, -1, 0, 0);
    exec(32'h0, 1'b1, 1000);
    do_reset("timeout_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
